// File: rtl/regs_param_2023211063.sv
// -----------------------------------------------------------------------------
// regs_param_2023211063
// Parametrised general-purpose register file with a post-reset clearing
// sequence and a request/acknowledge debug (JTAG) port.
//
// Parameters:
//   DATA_W    register width in bits
//   ADDR_W    address width; DEPTH = 2**ADDR_W
//   OVER_REG  index of the "test over" register
//   SUCC_REG  index of the "test success" register
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   we_i, waddr_i, wdata_i   core write port (from ex)
//   raddr1_i/2_i, rdata1_o/2_o  combinational read ports (to id)
//   jtag_req_i, jtag_we_i, jtag_addr_i, jtag_data_i  debug request
//   jtag_ack_o, jtag_data_o  one-cycle completion pulse and registered read data
//   busy_o                   high while the register file is being cleared
//   over_o, succ_o           inverted bit 0 of the status registers
//
// Configuration macro:
//   REGS_BYPASS_EN  forward a same-cycle core write to the read ports
// -----------------------------------------------------------------------------
module regs_param_2023211063 #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int OVER_REG = 26,
   parameter int SUCC_REG = 27
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o,
   input  logic              jtag_req_i,
   input  logic              jtag_we_i,
   input  logic [ADDR_W-1:0] jtag_addr_i,
   input  logic [DATA_W-1:0] jtag_data_i,
   output logic              jtag_ack_o,
   output logic [DATA_W-1:0] jtag_data_o,
   output logic              busy_o,
   output logic              over_o,
   output logic              succ_o
);

   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] OVER_IDX = ADDR_W'(OVER_REG);
   localparam logic [ADDR_W-1:0] SUCC_IDX = ADDR_W'(SUCC_REG);

   typedef enum logic [1:0] {CLEAR, READY, PEND} state_t;

   state_t            state;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [ADDR_W-1:0] clr_idx;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_data;

   logic              core_wr;
   logic              jtag_fire;
   logic              pend_commit;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              fwd1;
   logic              fwd2;

   // A core write only counts outside CLEAR and never targets x0.
   assign core_wr     = we_i && (waddr_i != '0) && (state != CLEAR);
   // Requests are not sampled while the previous ack is still high.
   assign jtag_fire   = (state == READY) && jtag_req_i && !jtag_ack_o;
   assign pend_commit = (state == PEND) && !we_i;

   // Single write port. The core always wins; a debug write only lands in a
   // cycle with we_i low, so the two never compete for the port.
   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (rst) begin
         if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_idx;
         end else if (core_wr) begin
            wr_en   = 1'b1;
            wr_addr = waddr_i;
            wr_data = wdata_i;
         end else if (jtag_fire && jtag_we_i && !we_i) begin
            wr_en   = (jtag_addr_i != '0);
            wr_addr = jtag_addr_i;
            wr_data = jtag_data_i;
         end else if (pend_commit) begin
            wr_en   = (pend_addr != '0);
            wr_addr = pend_addr;
            wr_data = pend_data;
         end
      end
   end

   // NOTE: the array has no reset; the clearing sequence zeroes it instead,
   // which keeps it mappable onto plain storage. x0 is never written.
   always_ff @(posedge clk) begin
      if (wr_en) regs[wr_addr] <= wr_data;
   end

   // Control FSM with registered debug outputs. The pending payload needs no
   // reset because it is only consumed in PEND.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= CLEAR;
         clr_idx     <= ADDR_W'(1);
         jtag_ack_o  <= 1'b0;
         jtag_data_o <= '0;
      end else begin
         jtag_ack_o <= 1'b0;
         unique case (state)
            CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == LAST_IDX) state <= READY;
            end
            READY: begin
               if (jtag_fire) begin
                  if (!jtag_we_i) begin
                     jtag_data_o <= (jtag_addr_i == '0) ? '0 : regs[jtag_addr_i];
                     jtag_ack_o  <= 1'b1;
                  end else if (we_i) begin
                     // Core owns the port this cycle: defer rather than drop.
                     pend_addr <= jtag_addr_i;
                     pend_data <= jtag_data_i;
                     state     <= PEND;
                  end else begin
                     jtag_ack_o <= 1'b1;
                  end
               end
            end
            PEND: begin
               if (!we_i) begin
                  jtag_ack_o <= 1'b1;
                  state      <= READY;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

`ifdef REGS_BYPASS_EN
   assign fwd1 = core_wr && (raddr1_i == waddr_i);
   assign fwd2 = core_wr && (raddr2_i == waddr_i);
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   assign rdata1_o = ((raddr1_i == '0) || (state == CLEAR)) ? '0 :
                     fwd1 ? wdata_i : regs[raddr1_i];
   assign rdata2_o = ((raddr2_i == '0) || (state == CLEAR)) ? '0 :
                     fwd2 ? wdata_i : regs[raddr2_i];

   assign busy_o = (state == CLEAR);
   assign over_o = ~regs[OVER_IDX][0];
   assign succ_o = ~regs[SUCC_IDX][0];

endmodule

// File: tb/tb_regs_param_2023211063.sv
// -----------------------------------------------------------------------------
// tb_regs_param_2023211063
// Scoreboard bench: stimulus pushes expected port values and expected debug
// acks into queues; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_regs_param_2023211063;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef enum {K_RD1, K_RD2, K_BUSY, K_OVER, K_SUCC, K_ACK, K_JDATA} kind_t;

   typedef struct {
      kind_t       kind;
      logic [31:0] exp;
      string       name;
   } port_exp_t;

   typedef struct {
      int          exp_cyc;
      bit          chk_data;
      logic [31:0] exp;
      string       name;
   } ack_exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          we_i;
   logic [AW-1:0] waddr_i;
   logic [DW-1:0] wdata_i;
   logic [AW-1:0] raddr1_i;
   logic [AW-1:0] raddr2_i;
   logic [DW-1:0] rdata1_o;
   logic [DW-1:0] rdata2_o;
   logic          jtag_req_i;
   logic          jtag_we_i;
   logic [AW-1:0] jtag_addr_i;
   logic [DW-1:0] jtag_data_i;
   logic          jtag_ack_o;
   logic [DW-1:0] jtag_data_o;
   logic          busy_o;
   logic          over_o;
   logic          succ_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   port_exp_t port_q[$];
   ack_exp_t  ack_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   regs_param_2023211063 dut (
      .clk        (clk),
      .rst        (rst),
      .we_i       (we_i),
      .waddr_i    (waddr_i),
      .wdata_i    (wdata_i),
      .raddr1_i   (raddr1_i),
      .raddr2_i   (raddr2_i),
      .rdata1_o   (rdata1_o),
      .rdata2_o   (rdata2_o),
      .jtag_req_i (jtag_req_i),
      .jtag_we_i  (jtag_we_i),
      .jtag_addr_i(jtag_addr_i),
      .jtag_data_i(jtag_data_i),
      .jtag_ack_o (jtag_ack_o),
      .jtag_data_o(jtag_data_o),
      .busy_o     (busy_o),
      .over_o     (over_o),
      .succ_o     (succ_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: compares queued port expectations and every debug ack.
   always @(negedge clk) begin : monitor
      port_exp_t   pe;
      ack_exp_t    ae;
      logic [31:0] act;
      while (port_q.size() > 0) begin
         pe = port_q.pop_front();
         case (pe.kind)
            K_RD1:   act = rdata1_o;
            K_RD2:   act = rdata2_o;
            K_BUSY:  act = 32'(busy_o);
            K_OVER:  act = 32'(over_o);
            K_SUCC:  act = 32'(succ_o);
            K_ACK:   act = 32'(jtag_ack_o);
            default: act = jtag_data_o;
         endcase
         check(pe.name, act, pe.exp);
      end
      if (jtag_ack_o) begin
         if (ack_q.size() == 0) begin
            check("unexpected_ack", 32'(jtag_ack_o), 32'd0);
         end else begin
            ae = ack_q.pop_front();
            check({ae.name, "_latency"}, 32'(cyc), 32'(ae.exp_cyc));
            if (ae.chk_data) check({ae.name, "_data"}, jtag_data_o, ae.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_port(input kind_t k, input logic [31:0] v, input string n);
      port_q.push_back('{kind: k, exp: v, name: n});
   endtask

   task automatic exp_ack(input int lat, input bit chk, input logic [31:0] v, input string n);
      ack_q.push_back('{exp_cyc: cyc + lat, chk_data: chk, exp: v, name: n});
   endtask

   task automatic wait_ack(input string n);
      int k = 0;
      while (!jtag_ack_o && k < 20) begin
         tick();
         k++;
      end
      if (!jtag_ack_o) check({n, "_timeout"}, 32'(jtag_ack_o), 32'd1);
   endtask

   task automatic wait_clear(input string n);
      int cnt = 0;
      while (busy_o && cnt < 100) begin
         cnt++;
         tick();
      end
      check(n, 32'(cnt), 32'd31);
   endtask

   task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      we_i    = 1'b1;
      waddr_i = a;
      wdata_i = d;
      tick();
      we_i    = 1'b0;
   endtask

   // Uncontended debug access: ack expected one cycle after the request.
   task automatic jtag_op(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit chk, input logic [31:0] exp, input string n);
      jtag_req_i  = 1'b1;
      jtag_we_i   = w;
      jtag_addr_i = a;
      jtag_data_i = d;
      exp_ack(1, chk, exp, n);
      tick();
      wait_ack(n);
      jtag_req_i = 1'b0;
      tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
      raddr1_i = '0; raddr2_i = '0;
      jtag_req_i = 1'b0; jtag_we_i = 1'b0; jtag_addr_i = '0; jtag_data_i = '0;

      // Reset held for three cycles.
      repeat (3) tick();
      raddr1_i = 5'd5;
      exp_port(K_BUSY,  32'd1, "reset_busy");
      exp_port(K_ACK,   32'd0, "reset_ack");
      exp_port(K_JDATA, 32'd0, "reset_jdata");
      exp_port(K_RD1,   32'd0, "clear_read_zero");
      rst = 1'b1;
      wait_clear("clear_cycles");

      // Every register reads zero; status bits high.
      exp_port(K_OVER, 32'd1, "post_clear_over");
      exp_port(K_SUCC, 32'd1, "post_clear_succ");
      for (int i = 0; i < 32; i++) begin
         raddr1_i = 5'(i);
         raddr2_i = 5'(31 - i);
         exp_port(K_RD1, 32'd0, $sformatf("sweep_rd1_x%0d", i));
         exp_port(K_RD2, 32'd0, $sformatf("sweep_rd2_x%0d", 31 - i));
         tick();
      end

      // Same-cycle read of a register being written.
      we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF;
      raddr1_i = 5'd5; raddr2_i = 5'd5;
`ifdef REGS_BYPASS_EN
      exp_port(K_RD1, 32'hDEADBEEF, "bypass_rd1_same");
      exp_port(K_RD2, 32'hDEADBEEF, "bypass_rd2_same");
`else
      exp_port(K_RD1, 32'd0, "nobypass_rd1_same");
      exp_port(K_RD2, 32'd0, "nobypass_rd2_same");
`endif
      tick();
      we_i = 1'b0;
      exp_port(K_RD1, 32'hDEADBEEF, "write_rd1_next");
      tick();

      // Contended debug write: core writes three cycles in a row.
      jtag_req_i = 1'b1; jtag_we_i = 1'b1; jtag_addr_i = 5'd7; jtag_data_i = 32'h1234;
      exp_ack(4, 1'b0, 32'd0, "jtag_contended");
      we_i = 1'b1; waddr_i = 5'd10; wdata_i = 32'hA0A0A0A0;
      tick();
      waddr_i = 5'd11; wdata_i = 32'hB1B1B1B1;
      tick();
      waddr_i = 5'd12; wdata_i = 32'hC2C2C2C2;
      tick();
      we_i = 1'b0;
      raddr1_i = 5'd7;
      exp_port(K_RD1, 32'd0, "pend_x7_still_old");
      tick();
      wait_ack("jtag_contended");
      jtag_req_i = 1'b0;
      raddr1_i = 5'd7; raddr2_i = 5'd10;
      exp_port(K_RD1, 32'h1234,     "pend_x7_committed");
      exp_port(K_RD2, 32'hA0A0A0A0, "core_x10_intact");
      tick();
      raddr1_i = 5'd11; raddr2_i = 5'd12;
      exp_port(K_RD1, 32'hB1B1B1B1, "core_x11_intact");
      exp_port(K_RD2, 32'hC2C2C2C2, "core_x12_intact");
      tick();

      // Status registers and debug read.
      core_write(5'd26, 32'h1);
      exp_port(K_OVER, 32'd0, "over_after_write");
      exp_port(K_SUCC, 32'd1, "succ_before_write");
      jtag_op(1'b0, 5'd26, 32'd0, 1'b1, 32'h1, "jtag_read_x26");
      core_write(5'd27, 32'h1);
      exp_port(K_SUCC, 32'd0, "succ_after_write");
      tick();

      // x0 is never written by either port.
      we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'hFFFFFFFF;
      raddr1_i = 5'd0; raddr2_i = 5'd0;
      exp_port(K_RD1, 32'd0, "x0_core_same");
      tick();
      we_i = 1'b0;
      exp_port(K_RD1, 32'd0, "x0_core_next");
      jtag_op(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'd0, "jtag_write_x0");
      jtag_op(1'b0, 5'd0, 32'd0, 1'b1, 32'd0, "jtag_read_x0");
      exp_port(K_RD2, 32'd0, "x0_after_jtag");

      // Uncontended debug write then debug and core reads.
      jtag_op(1'b1, 5'd9, 32'h55AA55AA, 1'b0, 32'd0, "jtag_write_x9");
      raddr1_i = 5'd9;
      exp_port(K_RD1, 32'h55AA55AA, "x9_after_jtag");
      jtag_op(1'b0, 5'd9, 32'd0, 1'b1, 32'h55AA55AA, "jtag_read_x9");

      // Reset in the middle of clearing (index 10).
      rst = 1'b0;
      tick();
      rst = 1'b1;
      repeat (9) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      wait_clear("midclear_restart_cycles");
      raddr1_i = 5'd10; raddr2_i = 5'd9;
      exp_port(K_RD1, 32'd0, "midclear_x10_zero");
      exp_port(K_RD2, 32'd0, "midclear_x9_zero");
      tick();

      // Reset while a debug write is pending: no ack, write discarded.
      jtag_req_i = 1'b1; jtag_we_i = 1'b1; jtag_addr_i = 5'd20; jtag_data_i = 32'hBAD0BAD0;
      we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h33;
      tick();
      tick();
      rst = 1'b0; we_i = 1'b0; jtag_req_i = 1'b0;
      tick();
      rst = 1'b1;
      exp_port(K_ACK, 32'd0, "pend_reset_no_ack");
      wait_clear("pend_reset_clear_cycles");
      raddr1_i = 5'd20; raddr2_i = 5'd3;
      exp_port(K_RD1, 32'd0, "pend_x20_discarded");
      exp_port(K_RD2, 32'd0, "pend_x3_cleared");
      repeat (3) tick();

      check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
